// File: rtl/condicionador_entradas_if.sv
// Raw board inputs and conditioned A/B levels, pulses and Busy shared between
// the input conditioner and the control unit.
interface condicionador_entradas_if;
    logic RawA;
    logic RawB;
    logic A;
    logic B;
    logic APulse;
    logic BPulse;
    logic Busy;

    modport master (
        output RawA, RawB,
        input  A, B, APulse, BPulse, Busy
    );

    modport slave (
        input  RawA, RawB,
        output A, B, APulse, BPulse, Busy
    );
endinterface

// File: rtl/condicionador_entradas.sv
// Two independent input channels: 2-FF synchronizer, debounce FSM, registered level and rise pulse.
// Optional macro COND_ACTIVE_LOW_EN inverts the raw inputs (buttons that pull low when pressed).
module condicionador_entradas #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    condicionador_entradas_if.slave  bus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] raw_eff;
    logic [1:0] level;
    logic [1:0] pulse;
    logic [1:0] busy;

    assign raw = {bus.RawB, bus.RawA};

`ifdef COND_ACTIVE_LOW_EN
    assign raw_eff = ~raw;
`else
    assign raw_eff = raw;
`endif

    genvar ch;
    for (ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync_p0;
        logic             sync_p1;
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level_q;
        logic             level_nxt;
        logic             pulse_q;
        logic             pulse_nxt;

        // Stage p0/p1: synchronizer; FSM, counter, level and pulse registers
        always_ff @(posedge Clock) begin
            if (Reset) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
                state   <= STABLE_LO;
                cnt     <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                sync_p0 <= raw_eff[ch];
                sync_p1 <= sync_p0;
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                level_q <= level_nxt;
                pulse_q <= pulse_nxt;
            end
        end

        // Counter restarts at zero on every state change
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            level_nxt = level_q;
            pulse_nxt = 1'b0;
            case (state)
                STABLE_LO: begin
                    if (sync_p1) begin
                        state_nxt = CHK_HI;
                        cnt_nxt   = '0;
                    end
                end
                CHK_HI: begin
                    if (!sync_p1) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync_p1) begin
                        state_nxt = CHK_LO;
                        cnt_nxt   = '0;
                    end
                end
                CHK_LO: begin
                    if (sync_p1) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign level[ch] = level_q;
        assign pulse[ch] = pulse_q;
        assign busy[ch]  = (state == CHK_HI) || (state == CHK_LO);
    end

    assign bus.A      = level[0];
    assign bus.B      = level[1];
    assign bus.APulse = pulse[0];
    assign bus.BPulse = pulse[1];
    assign bus.Busy   = |busy;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas with DEBOUNCE_CYCLES=4; output vector is {A,B,APulse,BPulse,Busy}.
module tb_condicionador_entradas;

    localparam int DEB = 4;

    logic Clock = 1'b0;
    logic Reset;

    condicionador_entradas_if bus();

    condicionador_entradas #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst;
        logic       ra;
        logic       rb;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [4:0] outs();
        return {bus.A, bus.B, bus.APulse, bus.BPulse, bus.Busy};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {A,B,AP,BP,Busy}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ra, input logic rb);
        Reset    = rst;
        bus.RawA = ra;
        bus.RawB = rb;
        @(posedge Clock);
        #1;
    endtask

    task automatic add(input string n, input logic rst, input logic ra, input logic rb,
                       input logic [4:0] e);
        vec_t v;
        v.rst  = rst;
        v.ra   = ra;
        v.rb   = rb;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        Reset    = 1'b1;
        bus.RawA = 1'b0;
        bus.RawB = 1'b0;

`ifdef COND_ACTIVE_LOW_EN
        // Idle-high raw pins must read as inactive from reset onward
        step(1'b1, 1'b1, 1'b1);
        check("al_reset", outs(), 5'b00000);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check($sformatf("al_idle_%0d", k), outs(), 5'b00000);
        end
        for (int k = 1; k <= 8; k++) begin
            logic [4:0] e;
            step(1'b0, 1'b0, 1'b1);
            if (k < 3)       e = 5'b00000;
            else if (k < 7)  e = 5'b00001;
            else if (k == 7) e = 5'b10100;
            else             e = 5'b10000;
            check($sformatf("al_press_e%0d", k), outs(), e);
        end
`else
        add("reset", 1'b1, 1'b0, 1'b0, 5'b00000);
        // Clean press on A: level at edge 7
        add("press_e1", 1'b0, 1'b1, 1'b0, 5'b00000);
        add("press_e2", 1'b0, 1'b1, 1'b0, 5'b00000);
        for (int k = 3; k <= 6; k++)
            add($sformatf("press_e%0d", k), 1'b0, 1'b1, 1'b0, 5'b00001);
        add("press_e7", 1'b0, 1'b1, 1'b0, 5'b10100);
        add("press_e8", 1'b0, 1'b1, 1'b0, 5'b10000);
        // Release on A: level drops at edge 7, no pulse
        add("rel_e1", 1'b0, 1'b0, 1'b0, 5'b10000);
        add("rel_e2", 1'b0, 1'b0, 1'b0, 5'b10000);
        for (int k = 3; k <= 6; k++)
            add($sformatf("rel_e%0d", k), 1'b0, 1'b0, 1'b0, 5'b10001);
        add("rel_e7", 1'b0, 1'b0, 1'b0, 5'b00000);
        add("rel_e8", 1'b0, 1'b0, 1'b0, 5'b00000);
        // Three-sample glitch is rejected
        add("gl_e1", 1'b0, 1'b1, 1'b0, 5'b00000);
        add("gl_e2", 1'b0, 1'b1, 1'b0, 5'b00000);
        add("gl_e3", 1'b0, 1'b1, 1'b0, 5'b00001);
        add("gl_e4", 1'b0, 1'b0, 1'b0, 5'b00001);
        add("gl_e5", 1'b0, 1'b0, 1'b0, 5'b00001);
        add("gl_e6", 1'b0, 1'b0, 1'b0, 5'b00000);
        add("gl_e7", 1'b0, 1'b0, 1'b0, 5'b00000);
        // Simultaneous rise on A and B
        add("sim_e1", 1'b0, 1'b1, 1'b1, 5'b00000);
        add("sim_e2", 1'b0, 1'b1, 1'b1, 5'b00000);
        for (int k = 3; k <= 6; k++)
            add($sformatf("sim_e%0d", k), 1'b0, 1'b1, 1'b1, 5'b00001);
        add("sim_e7", 1'b0, 1'b1, 1'b1, 5'b11110);
        add("sim_e8", 1'b0, 1'b1, 1'b1, 5'b11000);
        // Reset overrides held-high inputs
        add("rst_hi", 1'b1, 1'b1, 1'b1, 5'b00000);
        add("rst_after", 1'b0, 1'b0, 1'b0, 5'b00000);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ra, vecs[i].rb);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // Reset in the middle of qualification discards progress
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 1'b0);
        check("t5_mid_chk", outs(), 5'b00001);
        step(1'b1, 1'b1, 1'b0);
        check("t5_reset", outs(), 5'b00000);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b0);
            if (bus.A === 1'b1) begin
                n = k;
                break;
            end
        end
        check_int("t5_requalify_edges", n, 7);
        check("t5_requalify_outs", outs(), 5'b10100);
        step(1'b0, 1'b1, 1'b0);
        check("t5_pulse_done", outs(), 5'b10000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
